// File: rtl/frame_disassembly.sv
// rtl/frame_disassembly.sv - optical receive framer: oversampled bit recovery, preamble hunt, payload and parity extraction.
// Optional saturating error counter output enabled by FRAME_DISASSEMBLY_ERR_COUNT_EN.
module frame_disassembly #(
    parameter int          OVERSAMPLE  = 4,
    parameter logic [7:0]  PREAMBLE    = 8'hE2,
    parameter int          PAYLOAD_W   = 20,
    parameter int          MAX_GAP     = 64,
    parameter int          LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [PAYLOAD_W-1:0] dout,
    output logic                 dout_valid,
    output logic                 parity_err,
    output logic                 locked,
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
    output logic                 bit_strobe,
    output logic [11:0]          err_count
`else
    output logic                 bit_strobe
`endif
);

    localparam int PH_W   = $clog2(OVERSAMPLE);
    localparam int BC_W   = $clog2(PAYLOAD_W);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_MID    = PH_W'(OVERSAMPLE / 2);
    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(PAYLOAD_W - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0]  GAP_HIT   = GAP_W'(MAX_GAP - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_PARITY  = 2'd2;

    logic                 s1, s2, s3;
    logic                 line_edge;
    logic [PH_W-1:0]      ph;
    logic [1:0]           state;
    logic [7:0]           sr;
    logic [7:0]           sr_next;
    logic [BC_W-1:0]      bit_cnt;
    logic [PAYLOAD_W-1:0] payload;
    logic [GAP_W-1:0]     gap;
    logic [GOOD_W-1:0]    good;
    logic [GOOD_W-1:0]    good_next;
    logic                 parity_ok;
    logic                 parity_fail_ev;
    logic                 gap_loss_ev;

    // s1 is the metastability stage; s2 is the sampled bit and s2/s3 form the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign line_edge = s2 ^ s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (line_edge) begin
            ph <= '0;
        end else begin
            ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
        end
    end

    assign bit_strobe = (ph == PH_MID) && !line_edge;

    assign sr_next        = {sr[6:0], s2};
    assign parity_ok      = (s2 == ^payload);
    assign good_next      = (good == GOOD_MAX) ? GOOD_MAX : good + 1'b1;
    assign parity_fail_ev = bit_strobe && (state == ST_PARITY) && !parity_ok;
    assign gap_loss_ev    = bit_strobe && (state == ST_HUNT) && (gap == GAP_HIT) && locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            payload    <= '0;
            gap        <= '0;
            good       <= '0;
            locked     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            if (bit_strobe) begin
                case (state)
                    ST_HUNT: begin
                        sr <= sr_next;
                        if (sr_next == PREAMBLE) begin
                            bit_cnt <= '0;
                            state   <= ST_PAYLOAD;
                        end
                        // Gap saturates so a dead line drops lock only once.
                        if (gap != GAP_MAX) begin
                            gap <= gap + 1'b1;
                            if (gap == GAP_HIT) begin
                                locked <= 1'b0;
                                good   <= '0;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        payload <= {payload[PAYLOAD_W-2:0], s2};
                        if (bit_cnt == BC_LAST) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (parity_ok) begin
                            dout       <= payload;
                            dout_valid <= 1'b1;
                            good       <= good_next;
                            if (good_next == GOOD_MAX) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            parity_err <= 1'b1;
                            good       <= '0;
                            locked     <= 1'b0;
                        end
                        sr    <= '0;
                        gap   <= '0;
                        state <= ST_HUNT;
                    end
                    default: begin
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((parity_fail_ev || gap_loss_ev) && (err_count != 12'hFFF)) begin
            err_count <= err_count + 12'd1;
        end
    end
`else
    logic unused_ev;
    assign unused_ev = parity_fail_ev ^ gap_loss_ev;
`endif

endmodule

// File: tb/tb_frame_disassembly.sv
// tb/tb_frame_disassembly.sv - directed self-checking bench for frame_disassembly.
module tb_frame_disassembly;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic [19:0] dout;
    logic        dout_valid;
    logic        parity_err;
    logic        locked;
    logic        bit_strobe;
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
    logic [11:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    frame_disassembly dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .locked     (locked),
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
        .bit_strobe (bit_strobe),
        .err_count  (err_count)
`else
        .bit_strobe (bit_strobe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records every output event for the scenario tasks to inspect.
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          last_strobe_cyc = 0;
    int          perr_cnt = 0;
    int          both_cnt = 0;
    int          fall_strobe = 0;
    bit          fall_seen = 0;
    logic        prev_locked = 1'b0;
    logic [19:0] vq[$];
    logic        lq[$];
    int          dq[$];
    int          sq[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dout_valid) begin
            vq.push_back(dout);
            lq.push_back(locked);
            dq.push_back(cyc - last_strobe_cyc);
            sq.push_back(strobe_cnt);
        end
        if (parity_err) perr_cnt = perr_cnt + 1;
        if (parity_err && dout_valid) both_cnt = both_cnt + 1;
        if (prev_locked && !locked) begin
            fall_seen   = 1;
            fall_strobe = strobe_cnt;
        end
        prev_locked = locked;
        if (bit_strobe) begin
            strobe_cnt      = strobe_cnt + 1;
            last_strobe_cyc = cyc;
        end
    end

    // Line driver; in jitter mode each run of equal bits alternates 5/3 clk periods.
    bit   jit = 0;
    logic last_bit = 1'b0;
    int   run_pos = 0;

    task automatic send_bit(input logic b);
        int n;
        if (b != last_bit) run_pos = 0;
        else               run_pos = run_pos + 1;
        last_bit = b;
        n = jit ? ((run_pos % 2 == 0) ? 5 : 3) : 4;
        din = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_frame(input logic [19:0] p, input logic flip, input int nbits);
        logic [28:0] fb;
        fb = {8'hE2, p, (^p) ^ flip};
        for (int i = 28; i > 28 - nbits; i--) send_bit(fb[i]);
    endtask

    task automatic clear_mon();
        vq.delete(); lq.delete(); dq.delete(); sq.delete();
        perr_cnt  = 0;
        fall_seen = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (dout !== 20'h0)    begin bad++; $display("FAIL reset_dout got=%h want=00000", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dout_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err); end
        total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
        total++; if (bit_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", bit_strobe); end
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
        total++; if (err_count !== 12'h0) begin bad++; $display("FAIL reset_errcnt got=%h want=000", err_count); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_idle(8);
    endtask

    task automatic test_clean_stream();
        logic [19:0] exp_v[3];
        logic        exp_l[3];
        exp_v = '{20'hABCDE, 20'h00001, 20'hFFFFF};
        exp_l = '{1'b0, 1'b1, 1'b1};
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp_v[i], 1'b0, 29);
        send_idle(4);
        total++; if (vq.size() != 3) begin bad++; $display("FAIL clean_count got=%0d want=3", vq.size()); end
        for (int i = 0; i < 3 && i < vq.size(); i++) begin
            total++; if (vq[i] !== exp_v[i]) begin bad++; $display("FAIL clean_data%0d got=%h want=%h", i, vq[i], exp_v[i]); end
            total++; if (lq[i] !== exp_l[i]) begin bad++; $display("FAIL clean_locked%0d got=%b want=%b", i, lq[i], exp_l[i]); end
            total++; if (dq[i] != 1) begin bad++; $display("FAIL clean_latency%0d got=%0d want=1", i, dq[i]); end
        end
        total++; if (perr_cnt != 0) begin bad++; $display("FAIL clean_perr got=%0d want=0", perr_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_frame(20'h3C3C3, 1'b0, 18);
        #2 rst_n = 1'b0;
        din = 1'b0;
        last_bit = 1'b0;
        #1;
        total++; if (dout !== 20'h0) begin bad++; $display("FAIL midrst_dout got=%h want=00000", dout); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b want=0", locked); end
        total++; if (dout_valid !== 1'b0 || parity_err !== 1'b0 || bit_strobe !== 1'b0) begin
            bad++; $display("FAIL midrst_pulses got=%b%b%b want=000", dout_valid, parity_err, bit_strobe);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_idle(4);
        send_frame(20'h3C3C3, 1'b0, 29);
        send_idle(4);
        total++; if (vq.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", vq.size()); end
        else begin
            total++; if (vq[0] !== 20'h3C3C3) begin bad++; $display("FAIL midrst_data got=%h want=3c3c3", vq[0]); end
        end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_relock got=%b want=0", locked); end
    endtask

    task automatic test_parity_error();
        clear_mon();
        send_frame(20'h0AAAA, 1'b0, 29);
        send_idle(2);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL perr_prelock got=%b want=1", locked); end
        send_frame(20'h12345, 1'b1, 29);
        send_idle(2);
        total++; if (perr_cnt != 1) begin bad++; $display("FAIL perr_pulses got=%0d want=1", perr_cnt); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL perr_unlock got=%b want=0", locked); end
        total++; if (dout !== 20'h0AAAA) begin bad++; $display("FAIL perr_hold got=%h want=0aaaa", dout); end
        send_frame(20'h54321, 1'b0, 29);
        send_idle(2);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL perr_onegood got=%b want=0", locked); end
        send_frame(20'h6789A, 1'b0, 29);
        send_idle(2);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL perr_relock got=%b want=1", locked); end
        total++; if (vq.size() != 3) begin bad++; $display("FAIL perr_count got=%0d want=3", vq.size()); end
        else begin
            total++; if (vq[2] !== 20'h6789A) begin bad++; $display("FAIL perr_last got=%h want=6789a", vq[2]); end
        end
    endtask

    task automatic test_timing_drift();
        clear_mon();
        jit = 1;
        send_frame(20'h5A5A5, 1'b0, 29);
        send_frame(20'h5A5A5, 1'b0, 29);
        send_idle(6);
        jit = 0;
        send_idle(2);
        total++; if (vq.size() != 2) begin bad++; $display("FAIL drift_count got=%0d want=2", vq.size()); end
        for (int i = 0; i < 2 && i < vq.size(); i++) begin
            total++; if (vq[i] !== 20'h5A5A5) begin bad++; $display("FAIL drift_data%0d got=%h want=5a5a5", i, vq[i]); end
        end
        total++; if (perr_cnt != 0) begin bad++; $display("FAIL drift_perr got=%0d want=0", perr_cnt); end
    endtask

    task automatic test_false_preamble();
        clear_mon();
        send_frame(20'hE2E2E, 1'b0, 29);
        send_idle(10);
        total++; if (vq.size() != 1) begin bad++; $display("FAIL fpre_count got=%0d want=1", vq.size()); end
        else begin
            total++; if (vq[0] !== 20'hE2E2E) begin bad++; $display("FAIL fpre_data got=%h want=e2e2e", vq[0]); end
        end
        total++; if (perr_cnt != 0) begin bad++; $display("FAIL fpre_perr got=%0d want=0", perr_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL fpre_locked got=%b want=1", locked); end
    endtask

    task automatic test_loss_of_signal();
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
        logic [11:0] ec0;
`endif
        clear_mon();
        send_frame(20'h0F0F0, 1'b0, 29);
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
        ec0 = err_count;
`endif
        send_idle(70);
        total++; if (vq.size() != 1) begin bad++; $display("FAIL los_count got=%0d want=1", vq.size()); end
        total++; if (!fall_seen) begin bad++; $display("FAIL los_fall got=none want=fall"); end
        else if (vq.size() == 1) begin
            total++; if (fall_strobe - sq[0] != 64) begin bad++; $display("FAIL los_strobes got=%0d want=64", fall_strobe - sq[0]); end
        end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL los_locked got=%b want=0", locked); end
`ifdef FRAME_DISASSEMBLY_ERR_COUNT_EN
        total++; if (err_count !== ec0 + 12'd1) begin bad++; $display("FAIL los_errcnt got=%h want=%h", err_count, ec0 + 12'd1); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_reset_mid_frame();
        test_parity_error();
        test_timing_drift();
        test_false_preamble();
        test_loss_of_signal();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL exclusive got=%0d want=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
